// File: rtl/muxn_pipe.sv
// N-way WIDTH-bit selector with a registered, back-pressurable output and a 2-entry skid buffer.
// Optional feature macro: MUXN_RANGE_CHECK_EN (flags out-of-range selects on sel_err).
module muxn_pipe #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] d,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } buf_state_t;

    buf_state_t state_reg, state_next;

    logic [WIDTH-1:0] out_data_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic [WIDTH-1:0] lane_data [N];
    logic [WIDTH-1:0] sel_data;

    logic accept;
    logic drain;
    logic load_out_in;
    logic load_out_skid;
    logic load_skid;

    // Each lane is masked by its own decode; an out-of-range select matches no lane and yields zeros.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign lane_data[gi] = (sel == SELW'(gi)) ? d[gi*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | lane_data[i];
        end
    end

    // Handshake flags come straight from the state flop, so in_ready never depends on out_ready.
    assign out_valid = (state_reg != ST_EMPTY);
    assign in_ready  = (state_reg != ST_FULL);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign y         = out_data_reg;

    always_comb begin
        state_next    = state_reg;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    load_out_in = 1'b1;
                    state_next  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    load_skid  = 1'b1;
                    state_next = ST_FULL;
                end else if (accept && drain) begin
                    load_out_in = 1'b1;
                end else if (drain) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    load_out_skid = 1'b1;
                    state_next    = ST_ONE;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_EMPTY;
            out_data_reg  <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load_out_in) begin
                out_data_reg <= sel_data;
            end else if (load_out_skid) begin
                out_data_reg <= skid_data_reg;
            end
            if (load_skid) begin
                skid_data_reg <= sel_data;
            end
        end
    end

`ifdef MUXN_RANGE_CHECK_EN
    logic sel_oor;
    logic out_err_reg;
    logic skid_err_reg;

    assign sel_oor = ({1'b0, sel} >= (SELW+1)'(N));

    // The error bit rides alongside its data through the same load enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_err_reg  <= 1'b0;
            skid_err_reg <= 1'b0;
        end else begin
            if (load_out_in) begin
                out_err_reg <= sel_oor;
            end else if (load_out_skid) begin
                out_err_reg <= skid_err_reg;
            end
            if (load_skid) begin
                skid_err_reg <= sel_oor;
            end
        end
    end

    assign sel_err = out_err_reg;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed self-checking bench for muxn_pipe: a 4-way instance for the pipeline behaviour
// and a 3-way instance for the out-of-range select behaviour.
module tb_muxn_pipe;

    logic             clk;
    logic             reset;

    logic [4*64-1:0]  d;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      y;
    logic             out_valid;
    logic             out_ready;
    logic             sel_err;

    logic [3*64-1:0]  d3;
    logic [1:0]       sel3;
    logic             in_valid3;
    logic             in_ready3;
    logic [63:0]      y3;
    logic             out_valid3;
    logic             out_ready3;
    logic             sel_err3;

    int total;
    int bad;

    muxn_pipe #(.WIDTH(64), .N(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    muxn_pipe #(.WIDTH(64), .N(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .d         (d3),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .y         (y3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .sel_err   (sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        sel      = 2'd2;
        out_ready = 1'b0;
        in_valid3 = 1'b1;
        sel3      = 2'd1;
        out_ready3 = 1'b0;
        step();
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++;
        if (y !== 64'h0) begin bad++; $display("FAIL reset_y got=%h exp=0", y); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++;
        if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
        total++;
        if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin
            bad++; $display("FAIL reset_dut3 out_valid=%b in_ready=%b exp 0/1", out_valid3, in_ready3);
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        $display("reset: out_valid=%b y=%h in_ready=%b", out_valid, y, in_ready);
    endtask

    task automatic test_streaming();
        logic [63:0] exp_y;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel      = 2'(i);
            in_valid = 1'b1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
            step();
            exp_y = 64'h1111 * 64'(i + 1);
            total++;
            if (out_valid !== 1'b1 || y !== exp_y) begin
                bad++; $display("FAIL stream_y[%0d] valid=%b got=%h exp=%h", i, out_valid, y, exp_y);
            end
            $display("stream: sel=%0d y=%h out_valid=%b", i, y, out_valid);
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        step();
        sel = 2'd1;
        step();
        sel = 2'd2;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || y !== 64'h1111 || in_ready !== 1'b0) begin
                bad++; $display("FAIL stall_hold[%0d] valid=%b y=%h rdy=%b exp 1/1111/0", k, out_valid, y, in_ready);
            end
            $display("stall: cycle=%0d y=%h in_ready=%b", k, y, in_ready);
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || y !== 64'h2222) begin
            bad++; $display("FAIL stall_drain_b valid=%b got=%h exp=2222", out_valid, y);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || y !== 64'h3333) begin
            bad++; $display("FAIL stall_drain_c valid=%b got=%h exp=3333", out_valid, y);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b exp=0", out_valid); end
        $display("stall: drained in order, out_valid=%b", out_valid);
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_y;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd3;
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sel = 2'(k % 4);
            step();
            exp_y = 64'h1111 * 64'((k % 4) + 1);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || y !== exp_y) begin
                bad++; $display("FAIL b2b[%0d] valid=%b rdy=%b got=%h exp=%h", k, out_valid, in_ready, y, exp_y);
            end
            $display("b2b: beat=%0d y=%h in_ready=%b", k, y, in_ready);
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_range();
        logic exp_err;
`ifdef MUXN_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        out_ready3 = 1'b1;
        in_valid3  = 1'b1;
        sel3       = 2'd3;
        step();
        total++;
        if (out_valid3 !== 1'b1 || y3 !== 64'h0 || sel_err3 !== exp_err) begin
            bad++; $display("FAIL range_oor valid=%b y=%h err=%b exp 1/0/%b", out_valid3, y3, sel_err3, exp_err);
        end
        $display("range: sel=3 y=%h sel_err=%b", y3, sel_err3);
        sel3 = 2'd1;
        step();
        total++;
        if (out_valid3 !== 1'b1 || y3 !== 64'hA001 || sel_err3 !== 1'b0) begin
            bad++; $display("FAIL range_legal valid=%b y=%h err=%b exp 1/a001/0", out_valid3, y3, sel_err3);
        end
        $display("range: sel=1 y=%h sel_err=%b", y3, sel_err3);
        sel3 = 2'd2;
        step();
        total++;
        if (y3 !== 64'hA002 || sel_err3 !== 1'b0) begin
            bad++; $display("FAIL range_top y=%h err=%b exp a002/0", y3, sel_err3);
        end
        in_valid3 = 1'b0;
        step();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd1;
        step();
        sel = 2'd2;
        step();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL rfull_setup rdy=%b valid=%b exp 0/1", in_ready, out_valid);
        end
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 64'h0) begin
            bad++; $display("FAIL rfull_after valid=%b rdy=%b y=%h exp 0/1/0", out_valid, in_ready, y);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL rfull_ghost[%0d] valid=%b y=%h exp valid=0", k, out_valid, y);
            end
        end
        $display("reset_full: out_valid=%b in_ready=%b", out_valid, in_ready);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        d          = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
        sel        = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        d3         = {64'hA002, 64'hA001, 64'hA000};
        sel3       = '0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b0;
        #2;
        test_reset();
        test_streaming();
        test_stall();
        test_back_to_back();
        test_range();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
